prim_onehot_rr_arb: RTL and testbench

Round-robin arbiter that shares one downstream resource between `N` requesters and emits a registered one-hot grant, a binary grant index and a valid flag under a valid/ready handshake. The grant is locked until the downstream consumer accepts it. Every cycle an internal hardened consistency check cross-validates the grant vector, the index and the valid flag, and reports any mismatch on a sticky error output for alert generation. The block sits in front of any shared datapath that takes a one-hot select: register-file write port, bus master port, or shared functional unit.

---
 rtl/prim_onehot_rr_arb.sv | 178 +++++++++++++++++
 tb/tb_prim_onehot_rr_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prim_onehot_rr_arb.sv
// prim_onehot_rr_arb: round-robin arbiter with a locked, registered one-hot
// grant, binary index and valid flag under a valid/ready handshake. A
// combinational consistency check on the registered outputs feeds a sticky
// integrity error for alert generation.
module prim_onehot_rr_arb #(
  parameter  int N    = 8,
  localparam int IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            err_o
);

  // Sparse encoding: the two legal codes are three bit-flips apart.
  typedef enum logic [2:0] {
    IDLE = 3'b101,
    HOLD = 3'b010
  } state_e;

  state_e          state_q;
  state_e          state_nxt_s;
  logic [N-1:0]    gnt_q;
  logic [N-1:0]    gnt_nxt_s;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] idx_nxt_s;
  logic            valid_q;
  logic            valid_nxt_s;
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] ptr_nxt_s;
  logic            err_q;

  logic            accept_s;
  logic [IdxW-1:0] ptr_inc_s;
  logic [IdxW-1:0] arb_base_s;
  logic [IdxW-1:0] pos_s;
  logic            win_found_s;
  logic [IdxW-1:0] win_idx_s;
  logic [N-1:0]    gnt_win_s;
  logic            state_bad_s;
  logic            check_fail_s;

  // Increment modulo N; anything at or beyond N-1 wraps to 0 so the pointer
  // never reaches the unused codes when N is not a power of two.
  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] res;
    if (32'(idx) >= N - 1) begin
      res = '0;
    end else begin
      res = idx + IdxW'(1);
    end
    return res;
  endfunction

  // True when more than one bit of the vector is set.
  function automatic logic multi_hot(input logic [N-1:0] vec);
    return |(vec & (vec - N'(1)));
  endfunction

  assign accept_s   = valid_q & ready_i;
  assign ptr_inc_s  = wrap_inc(idx_q);
  // On a handshake the search already starts from the updated pointer.
  assign arb_base_s = (state_q == HOLD && accept_s) ? ptr_inc_s : ptr_q;

  // Round-robin search: first request at or above the base, wrapping at N.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    pos_s       = arb_base_s;
    for (int k = 0; k < N; k++) begin
      if (!win_found_s && req_i[pos_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = pos_s;
      end else begin
        win_found_s = win_found_s;
      end
      pos_s = wrap_inc(pos_s);
    end
  end

  // One-hot decode of the winning index.
  always_comb begin
    gnt_win_s            = '0;
    gnt_win_s[win_idx_s] = 1'b1;
  end

  // Next-state and next-grant logic; the grant is held until accepted.
  always_comb begin
    state_nxt_s = state_q;
    gnt_nxt_s   = gnt_q;
    idx_nxt_s   = idx_q;
    valid_nxt_s = valid_q;
    ptr_nxt_s   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          gnt_nxt_s   = gnt_win_s;
          idx_nxt_s   = win_idx_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (accept_s) begin
          ptr_nxt_s = ptr_inc_s;
          if (win_found_s) begin
            gnt_nxt_s   = gnt_win_s;
            idx_nxt_s   = win_idx_s;
            valid_nxt_s = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            gnt_nxt_s   = '0;
            valid_nxt_s = 1'b0;
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        gnt_nxt_s   = '0;
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State must agree with the valid flag; an illegal code is always an error.
  always_comb begin
    state_bad_s = 1'b0;
    case (state_q)
      IDLE:    state_bad_s = valid_q;
      HOLD:    state_bad_s = ~valid_q;
      default: state_bad_s = 1'b1;
    endcase
  end

  // Cross-check grant vector, index, valid flag and state every cycle.
  always_comb begin
    check_fail_s = multi_hot(gnt_q)
                 | (valid_q != (|gnt_q))
                 | (valid_q & ~gnt_q[idx_q])
                 | (32'(idx_q) >= N)
                 | state_bad_s;
  end

  // Arbiter registers and the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt_s;
      gnt_q   <= gnt_nxt_s;
      idx_q   <= idx_nxt_s;
      valid_q <= valid_nxt_s;
      ptr_q   <= ptr_nxt_s;
      err_q   <= err_q | check_fail_s;
    end
  end

  assign valid_o = valid_q;
  assign gnt_o   = gnt_q;
  assign idx_o   = idx_q;
  // Same-cycle error visibility, held afterwards by err_q.
  assign err_o   = check_fail_s | err_q;

endmodule

// File: tb/tb_prim_onehot_rr_arb.sv
// Testbench for prim_onehot_rr_arb: directed vectors, expected grants queued
// by the stimulus and popped by an independent negedge monitor.
module tb_prim_onehot_rr_arb;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
  } exp_t;

  logic       clk;
  logic       rst_i;
  logic [7:0] req_i;
  logic       ready_i;
  logic       valid_o;
  logic [7:0] gnt_o;
  logic [2:0] idx_o;
  logic       err_o;

  logic [4:0] req5;
  logic       rdy5;
  logic       valid5;
  logic [4:0] gnt5;
  logic [2:0] idx5;
  logic       err5;

  int   vectors;
  int   miscompares;
  logic mon_en;
  exp_t exp_q[$];
  logic [2:0] exp5_q[$];
  exp_t mon_e;
  logic [2:0] mon_i5;

  prim_onehot_rr_arb #(.N(8)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .ready_i(ready_i),
    .valid_o(valid_o),
    .gnt_o  (gnt_o),
    .idx_o  (idx_o),
    .err_o  (err_o)
  );

  prim_onehot_rr_arb #(.N(5)) dut5 (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .req_i  (req5),
    .ready_i(rdy5),
    .valid_o(valid5),
    .gnt_o  (gnt5),
    .idx_o  (idx5),
    .err_o  (err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the next posedge.
  task automatic cyc(input logic [7:0] req, input logic rdy);
    req_i   = req;
    ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_i   = 8'h00;
    ready_i = 1'b0;
    req5    = 5'b00000;
    #2 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] g, input logic [2:0] i);
    exp_t e;
    e.gnt = g;
    e.idx = i;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented grant is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && mon_en && valid_o) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant: got gnt %0h idx %0d, expected none", gnt_o, idx_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_vec", 32'(gnt_o), 32'(mon_e.gnt));
        chk("grant_idx", 32'(idx_o), 32'(mon_e.idx));
        chk("err_quiet", 32'(err_o), 32'd0);
      end
    end
    if (!rst_i && mon_en && valid5) begin
      if (exp5_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_grant5: got idx %0d, expected none", idx5);
      end else begin
        mon_i5 = exp5_q.pop_front();
        chk("grant5_idx", 32'(idx5), 32'(mon_i5));
        chk("grant5_onehot", 32'(gnt5), 32'(5'b00001) << mon_i5);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b1;
    rst_i       = 1'b0;
    req_i       = 8'h00;
    ready_i     = 1'b0;
    req5        = 5'b00000;
    rdy5        = 1'b1;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_gnt",   32'(gnt_o),   32'd0);
    chk("rst_idx",   32'(idx_o),   32'd0);
    chk("rst_err",   32'(err_o),   32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Fairness: all requesting, ready held high, grants 0..7,0 back to back.
    for (int i = 0; i < 8; i++) push(8'h01 << i, 3'(i));
    push(8'h01, 3'd0);
    for (int i = 0; i < 9; i++) cyc(8'hFF, 1'b1);
    cyc(8'h00, 1'b1);
    chk("fair_drained", 32'(exp_q.size()), 32'd0);
    chk("fair_idle", 32'(valid_o), 32'd0);
    chk("fair_err", 32'(err_o), 32'd0);

    // Single request from a fresh pointer.
    do_reset();
    push(8'h04, 3'd2);
    cyc(8'h04, 1'b1);
    cyc(8'h00, 1'b1);
    chk("single_valid_drop", 32'(valid_o), 32'd0);
    chk("single_ptr", 32'(dut.ptr_q), 32'd3);

    // Backpressure: grant 3 locked while requests change, then idx 4.
    for (int i = 0; i < 5; i++) push(8'h08, 3'd3);
    push(8'h10, 3'd4);
    cyc(8'h08, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(8'hF0, 1'b0);
      chk("lock_gnt", 32'(gnt_o), 32'h08);
    end
    cyc(8'hF0, 1'b1);
    cyc(8'h00, 1'b1);
    chk("lock_drained", 32'(exp_q.size()), 32'd0);

    // Non-power-of-two wrap on the N=5 instance.
    exp5_q.push_back(3'd0);
    exp5_q.push_back(3'd4);
    exp5_q.push_back(3'd0);
    exp5_q.push_back(3'd4);
    req5 = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 1'b0);
      chk("ptr5_range", 32'(dut5.ptr_q < 3'd5), 32'd1);
    end
    req5 = 5'b00000;
    cyc(8'h00, 1'b0);
    chk("ptr5_wrap", 32'(dut5.ptr_q), 32'd0);
    chk("wrap_drained", 32'(exp5_q.size()), 32'd0);

    // Asynchronous reset while holding a grant.
    cyc(8'h08, 1'b0);
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_gnt",   32'(gnt_o),   32'd0);
    chk("async_rst_idx",   32'(idx_o),   32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    push(8'h02, 3'd1);
    cyc(8'h82, 1'b1);
    cyc(8'h00, 1'b1);
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);

    // Fault: two grant bits set while valid.
    mon_en = 1'b0;
    cyc(8'h08, 1'b0);
    chk("prefault_err", 32'(err_o), 32'd0);
    force dut.gnt_q = 8'h06;
    #1;
    chk("multihot_err", 32'(err_o), 32'd1);
    @(posedge clk);
    #1;
    release dut.gnt_q;
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);
    chk("err_sticky", 32'(err_o), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err_o), 32'd0);

    // Fault: index disagrees with the grant vector.
    cyc(8'h08, 1'b0);
    chk("prefault2_err", 32'(err_o), 32'd0);
    force dut.idx_q = 3'd5;
    #1;
    chk("idx_mismatch_err", 32'(err_o), 32'd1);
    release dut.idx_q;
    do_reset();
    mon_en = 1'b1;

    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
